// File: rtl/panel_pkg.sv
// Shared types and constants for the scrolling LED panel: FSM state encoding,
// default geometry and the message ROM (one ROWS-bit column pattern per entry).
package panel_pkg;

  localparam int DEF_NUM_COLS = 8;
  localparam int DEF_ROWS     = 7;
  localparam int DEF_MSG_LEN  = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_t;

  // Column patterns of the scrolled message, entry 0 first; bit 0 is the top LED.
  localparam logic [DEF_ROWS-1:0] MSG_ROM [DEF_MSG_LEN] = '{
    7'h00, 7'h7F, 7'h08, 7'h08, 7'h7F, 7'h00, 7'h41, 7'h7F,
    7'h41, 7'h00, 7'h7F, 7'h40, 7'h40, 7'h00, 7'h3E, 7'h41,
    7'h41, 7'h3E, 7'h00, 7'h01, 7'h7F, 7'h01, 7'h00, 7'h7F,
    7'h09, 7'h06, 7'h00, 7'h5F, 7'h00, 7'h00, 7'h2A, 7'h55
  };

endpackage

// File: rtl/panel_tick_sync.sv
// Synchronises one divided square wave into clk and emits a single-cycle tick
// per rising edge; a level already high when reset releases is not an edge.
module panel_tick_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic tick
);

  logic [SYNC_STAGES-1:0] chain;
  logic [SYNC_STAGES-1:0] valid;
  logic                   prev;
  logic                   armed;
  logic                   sync_out;

  assign sync_out = chain[SYNC_STAGES-1];

  // armed waits until the chain holds real samples and has seen the input low,
  // so an input that is high out of reset needs a fresh rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
      valid <= '0;
      prev  <= 1'b0;
      armed <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], level};
      valid <= {valid[SYNC_STAGES-2:0], 1'b1};
      prev  <= sync_out;
      if (valid[SYNC_STAGES-1] && !sync_out)
        armed <= 1'b1;
    end
  end

  assign tick = sync_out & ~prev & armed;

endmodule

// File: rtl/panel_scroller.sv
// Column-multiplexed LED matrix driver scrolling the ROM message under an
// IDLE/RUN/PAUSED FSM. Optional PANEL_BLINK_EN blanks rows on alternate scroll periods.
module panel_scroller
  import panel_pkg::*;
#(
  parameter int NUM_COLS    = DEF_NUM_COLS,
  parameter int ROWS        = DEF_ROWS,
  parameter int MSG_LEN     = DEF_MSG_LEN,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clk_cont_in,
  input  logic                clk_ru_in,
  input  logic                start,
  input  logic                pause,
  input  logic                stop,
  input  logic                dir,
  input  logic                blink,
  output logic [NUM_COLS-1:0] col_sel,
  output logic [ROWS-1:0]     row_data,
  output logic                running,
  output logic                wrap_pulse
);

  localparam int CW    = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int OW    = $clog2(MSG_LEN);
  localparam int SUM_W = OW + 1;
  localparam logic [CW-1:0]    COL_LAST  = CW'(NUM_COLS - 1);
  localparam logic [OW-1:0]    OFF_LAST  = OW'(MSG_LEN - 1);
  localparam logic [SUM_W-1:0] MSG_LEN_S = SUM_W'(MSG_LEN);

  logic refresh_tick;
  logic scroll_tick;

  panel_tick_sync #(.SYNC_STAGES(SYNC_STAGES)) u_refresh_sync (
    .clk   (clk),
    .rst   (rst),
    .level (clk_cont_in),
    .tick  (refresh_tick)
  );

  panel_tick_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scroll_sync (
    .clk   (clk),
    .rst   (rst),
    .level (clk_ru_in),
    .tick  (scroll_tick)
  );

  state_t              state, state_next;
  logic [CW-1:0]       col_cnt, col_next;
  logic [OW-1:0]       offset, off_next;
  logic [NUM_COLS-1:0] col_sel_next;
  logic [ROWS-1:0]     row_reg, row_next;
  logic                wrap_next;
  logic                scroll_en;
  logic [SUM_W-1:0]    sum;

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (!stop && start) state_next = ST_RUN;
      ST_RUN:    if (stop) state_next = ST_IDLE;
                 else if (pause) state_next = ST_PAUSED;
      ST_PAUSED: if (stop) state_next = ST_IDLE;
                 else if (start && !pause) state_next = ST_RUN;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Counters and the column/row pair are computed together so that col_sel and
  // row_data always describe the same column, using the post-update offset.
  always_comb begin
    col_next     = col_cnt;
    off_next     = offset;
    wrap_next    = 1'b0;
    col_sel_next = col_sel;
    row_next     = row_reg;
    sum          = '0;
    scroll_en    = scroll_tick && (state == ST_RUN);
    if (state_next == ST_IDLE) begin
      col_next     = '0;
      off_next     = '0;
      col_sel_next = '0;
      row_next     = '0;
    end else if (state != ST_IDLE) begin
      if (refresh_tick)
        col_next = (col_cnt == COL_LAST) ? '0 : col_cnt + 1'b1;
      if (scroll_en) begin
        if (!dir) begin
          if (offset == OFF_LAST) begin
            off_next  = '0;
            wrap_next = 1'b1;
          end else begin
            off_next = offset + 1'b1;
          end
        end else begin
          if (offset == '0) begin
            off_next  = OFF_LAST;
            wrap_next = 1'b1;
          end else begin
            off_next = offset - 1'b1;
          end
        end
      end
      if (refresh_tick || scroll_en) begin
        sum = SUM_W'(off_next) + SUM_W'(col_next);
        if (sum >= MSG_LEN_S)
          sum = sum - MSG_LEN_S;
        col_sel_next = NUM_COLS'(1) << col_next;
        row_next     = ROWS'(MSG_ROM[sum[OW-1:0]]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      col_cnt    <= '0;
      offset     <= '0;
      col_sel    <= '0;
      row_reg    <= '0;
      running    <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      state      <= state_next;
      col_cnt    <= col_next;
      offset     <= off_next;
      col_sel    <= col_sel_next;
      row_reg    <= row_next;
      running    <= (state_next == ST_RUN);
      wrap_pulse <= wrap_next;
    end
  end

`ifdef PANEL_BLINK_EN
  logic blank_phase;

  always_ff @(posedge clk) begin
    if (rst)
      blank_phase <= 1'b0;
    else if (state != ST_RUN || state_next != ST_RUN || !blink)
      blank_phase <= 1'b0;
    else if (scroll_tick)
      blank_phase <= ~blank_phase;
  end

  assign row_data = blank_phase ? '0 : row_reg;
`else
  logic unused_blink;
  assign unused_blink = blink;
  assign row_data     = row_reg;
`endif

endmodule

// File: tb/tb_panel_scroller.sv
// Randomised self-checking bench for panel_scroller against a behavioural model
// of offset/column arithmetic, FSM control and (when PANEL_BLINK_EN) blanking.
module tb_panel_scroller;

  localparam int NC = 8;
  localparam int RW = 7;
  localparam int ML = 32;

  localparam logic [RW-1:0] ROM [ML] = '{
    7'h00, 7'h7F, 7'h08, 7'h08, 7'h7F, 7'h00, 7'h41, 7'h7F,
    7'h41, 7'h00, 7'h7F, 7'h40, 7'h40, 7'h00, 7'h3E, 7'h41,
    7'h41, 7'h3E, 7'h00, 7'h01, 7'h7F, 7'h01, 7'h00, 7'h7F,
    7'h09, 7'h06, 7'h00, 7'h5F, 7'h00, 7'h00, 7'h2A, 7'h55
  };

  typedef enum int {M_IDLE, M_RUN, M_PAUSED} mstate_t;

  logic clk = 1'b0;
  logic rst, clk_cont_in, clk_ru_in, start, pause, stop, dir, blink;
  logic [NC-1:0] col_sel;
  logic [RW-1:0] row_data;
  logic running, wrap_pulse;

  int total = 0;
  int bad = 0;
  int wrap_seen = 0;

  mstate_t mst;
  int mcol, moff, mwraps;
  logic [NC-1:0] mcolsel;
  logic [RW-1:0] mrow;
  bit mblank;

  panel_scroller dut (
    .clk         (clk),
    .rst         (rst),
    .clk_cont_in (clk_cont_in),
    .clk_ru_in   (clk_ru_in),
    .start       (start),
    .pause       (pause),
    .stop        (stop),
    .dir         (dir),
    .blink       (blink),
    .col_sel     (col_sel),
    .row_data    (row_data),
    .running     (running),
    .wrap_pulse  (wrap_pulse)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (wrap_pulse === 1'b1) wrap_seen++;

  function automatic logic [RW-1:0] exp_row();
    return mblank ? '0 : mrow;
  endfunction

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_output(input string tag);
    check_value({tag, "/col_sel"}, 32'(col_sel), 32'(mcolsel));
    check_value({tag, "/row_data"}, 32'(row_data), 32'(exp_row()));
    check_value({tag, "/running"}, 32'(running), 32'(mst == M_RUN));
  endtask

  task automatic model_idle();
    mst = M_IDLE;
    mcol = 0;
    moff = 0;
    mcolsel = '0;
    mrow = '0;
    mblank = 1'b0;
  endtask

  task automatic model_event(input bit r, input bit s, input bit d);
    bit upd;
    upd = 1'b0;
    if (mst != M_IDLE) begin
      if (r) begin
        mcol = (mcol + 1) % NC;
        upd = 1'b1;
      end
      if (s && mst == M_RUN) begin
        if (!d) begin
          moff = moff + 1;
          if (moff == ML) begin moff = 0; mwraps++; end
        end else begin
          if (moff == 0) begin moff = ML - 1; mwraps++; end
          else moff = moff - 1;
        end
        upd = 1'b1;
`ifdef PANEL_BLINK_EN
        if (blink) mblank = ~mblank;
`endif
      end
      if (upd) begin
        mcolsel = '0;
        mcolsel[mcol] = 1'b1;
        mrow = ROM[(moff + mcol) % ML];
      end
    end
  endtask

  task automatic model_control(input bit st, input bit pa, input bit sp);
    case (mst)
      M_IDLE:   if (!sp && st) mst = M_RUN;
      M_RUN:    if (sp) model_idle(); else if (pa) mst = M_PAUSED;
      M_PAUSED: if (sp) model_idle(); else if (st && !pa) mst = M_RUN;
      default:  model_idle();
    endcase
    if (mst != M_RUN) mblank = 1'b0;
  endtask

  // Raise the selected divider inputs mid-cycle, check nothing moves before the
  // third sampling edge, then check the update and wrap pulse on that edge.
  task automatic apply_stimulus(input bit r, input bit s, input bit d);
    int w0;
    @(negedge clk);
    dir = d;
    if (r) clk_cont_in = 1'b1;
    if (s) clk_ru_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_value("early/col_sel", 32'(col_sel), 32'(mcolsel));
    check_value("early/wrap", 32'(wrap_pulse), 32'(0));
    w0 = mwraps;
    model_event(r, s, d);
    @(posedge clk);
    #1;
    check_output("event");
    check_value("event/wrap", 32'(wrap_pulse), 32'(mwraps != w0));
    @(negedge clk);
    clk_cont_in = 1'b0;
    clk_ru_in = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic apply_control(input bit st, input bit pa, input bit sp, input string tag);
    @(negedge clk);
    start = st;
    pause = pa;
    stop = sp;
    @(negedge clk);
    start = 1'b0;
    pause = 1'b0;
    stop = 1'b0;
    model_control(st, pa, sp);
    repeat (2) @(negedge clk);
    check_output(tag);
  endtask

  task automatic set_blink(input bit v);
    @(negedge clk);
    blink = v;
    repeat (2) @(negedge clk);
    if (!v) mblank = 1'b0;
    check_output("blink");
  endtask

  initial begin
    rst = 1'b1;
    clk_cont_in = 1'b1;
    clk_ru_in = 1'b1;
    start = 1'b0;
    pause = 1'b0;
    stop = 1'b0;
    dir = 1'b0;
    blink = 1'b0;
    mwraps = 0;
    model_idle();

    repeat (5) @(negedge clk);
    check_output("in_reset");
    check_value("in_reset/wrap", 32'(wrap_pulse), 32'(0));
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check_output("after_reset");

    // Inputs were high across reset release: running must not see any tick.
    apply_control(1, 0, 0, "start");
    repeat (10) @(negedge clk);
    check_output("high_at_release");
    clk_cont_in = 1'b0;
    clk_ru_in = 1'b0;
    repeat (6) @(negedge clk);
    check_output("inputs_low");

    for (int i = 0; i < 9; i++) apply_stimulus(1, 0, 0);
    for (int i = 0; i < 32; i++) apply_stimulus(0, 1, 0);
    check_value("wraps_left", 32'(wrap_seen), 32'(mwraps));
    apply_stimulus(0, 1, 1);
    check_value("offset_after_right_wrap", 32'(moff), 32'(ML - 1));
    for (int i = 0; i < 4; i++) apply_stimulus(1, 1, 1'($urandom_range(0, 1)));

    apply_control(0, 1, 0, "pause");
    for (int i = 0; i < 4; i++) apply_stimulus(0, 1, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 3; i++) apply_stimulus(1, 0, 0);
    apply_stimulus(1, 1, 0);
    apply_control(1, 0, 0, "resume");

    set_blink(1);
    for (int i = 0; i < 4; i++) apply_stimulus(i[0], 1, 0);
    set_blink(0);

    for (int i = 0; i < 40; i++) begin
      int kind;
      kind = $urandom_range(0, 2);
      if (i % 8 == 7) set_blink(1'($urandom_range(0, 1)));
      apply_stimulus(kind != 1, kind != 0, 1'($urandom_range(0, 1)));
    end
    set_blink(0);

    apply_control(1, 0, 1, "stop_and_start");
    apply_stimulus(1, 1, 0);
    apply_control(1, 0, 0, "restart");
    apply_stimulus(1, 1, 1);
    apply_stimulus(1, 0, 0);
    apply_control(0, 1, 0, "pause2");
    apply_control(0, 0, 1, "stop_from_paused");
    check_value("wraps_total", 32'(wrap_seen), 32'(mwraps));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
